// File: rtl/fpu_control_word_apply.sv
// fpu_control_word_apply
//
// Takes control-word writes from the FPU control register and holds each one
// as pending. A pending word is committed to the core's active control fields
// only on an edge where the core is idle. This keeps rounding and precision
// from changing in the middle of an instruction. The block also registers the
// FERR request from the core's sticky exception flags and the active masks.
//
// Ports:
//   clk               system clock, rising edge
//   reset             synchronous, active-low reset
//   control_word_in   16-bit word from the control register
//   control_write     one-cycle write strobe
//   fpu_busy          core is executing; a high value blocks commit
//   status_exceptions sticky flags {PE,UE,OE,ZE,DE,IE}
//   active_cw         committed control word
//   exception_mask    active_cw[5:0]
//   precision_ctl     active_cw[9:8]
//   rounding_ctl      active_cw[11:10]
//   infinity_ctl      active_cw[12]
//   cw_pending        a write is waiting to be committed
//   cw_applied        one-cycle pulse after a commit edge
//   cw_overwritten    one-cycle pulse when an uncommitted word was replaced
//   apply_timeout     sticky; a write waited BUSY_TIMEOUT busy cycles
//   ferr_req          registered FPU error request

module fpu_control_word_apply #(
  parameter int BUSY_TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] control_word_in,
  input  logic        control_write,
  input  logic        fpu_busy,
  input  logic [5:0]  status_exceptions,
  output logic [15:0] active_cw,
  output logic [5:0]  exception_mask,
  output logic [1:0]  precision_ctl,
  output logic [1:0]  rounding_ctl,
  output logic        infinity_ctl,
  output logic        cw_pending,
  output logic        cw_applied,
  output logic        cw_overwritten,
  output logic        apply_timeout,
  output logic        ferr_req
);

  typedef enum logic {
    IDLE,
    PENDING
  } state_t;

  localparam logic [15:0] ACTIVE_RESET = 16'h037F;
  localparam logic [15:0] TIMEOUT_LAST = 16'(BUSY_TIMEOUT - 1);

  state_t      state, state_nxt;
  logic [15:0] active_q, active_nxt;
  logic [15:0] pending_q, pending_nxt;
  logic [15:0] wait_q, wait_nxt;
  logic        timeout_q, timeout_nxt;
  logic        applied_nxt;
  logic        overwritten_nxt;
  logic        ferr_nxt;

  // Next-state logic for the commit FSM and its datapath registers.
  // An idle edge in PENDING always commits the held word. A write on that
  // same edge simply becomes the next pending word, so nothing is lost and
  // no overwrite is reported.
  always_comb begin
    state_nxt       = state;
    active_nxt      = active_q;
    pending_nxt     = pending_q;
    wait_nxt        = wait_q;
    timeout_nxt     = timeout_q;
    applied_nxt     = 1'b0;
    overwritten_nxt = 1'b0;

    case (state)
      IDLE: begin
        if (control_write) begin
          pending_nxt = control_word_in;
          wait_nxt    = 16'h0000;
          state_nxt   = PENDING;
        end
      end

      PENDING: begin
        if (!fpu_busy) begin
          active_nxt  = pending_q;
          applied_nxt = 1'b1;
          timeout_nxt = 1'b0;
          if (control_write) begin
            pending_nxt = control_word_in;
            wait_nxt    = 16'h0000;
          end else begin
            state_nxt = IDLE;
          end
        end else if (control_write) begin
          // The core is still busy, so the last write wins.
          pending_nxt     = control_word_in;
          overwritten_nxt = 1'b1;
          wait_nxt        = 16'h0000;
        end else begin
          // A timeout is only reported. It never forces a commit.
          if (wait_q == TIMEOUT_LAST) begin
            timeout_nxt = 1'b1;
          end
          if (wait_q != 16'hFFFF) begin
            wait_nxt = wait_q + 16'h0001;
          end
        end
      end

      default: state_nxt = IDLE;
    endcase

    // This uses the pre-edge mask. A commit that unmasks a set flag
    // therefore raises the request one edge later.
    ferr_nxt = ~active_q[7] & (|(status_exceptions & ~active_q[5:0]));
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state          <= IDLE;
      active_q       <= ACTIVE_RESET;
      pending_q      <= 16'h0000;
      wait_q         <= 16'h0000;
      timeout_q      <= 1'b0;
      cw_applied     <= 1'b0;
      cw_overwritten <= 1'b0;
      ferr_req       <= 1'b0;
    end else begin
      state          <= state_nxt;
      active_q       <= active_nxt;
      pending_q      <= pending_nxt;
      wait_q         <= wait_nxt;
      timeout_q      <= timeout_nxt;
      cw_applied     <= applied_nxt;
      cw_overwritten <= overwritten_nxt;
      ferr_req       <= ferr_nxt;
    end
  end

  assign active_cw      = active_q;
  assign exception_mask = active_q[5:0];
  assign precision_ctl  = active_q[9:8];
  assign rounding_ctl   = active_q[11:10];
  assign infinity_ctl   = active_q[12];
  assign cw_pending     = (state == PENDING);
  assign apply_timeout  = timeout_q;

endmodule

// File: tb/tb_fpu_control_word_apply.sv
// tb_fpu_control_word_apply
//
// Drives fpu_control_word_apply through directed scenarios and then random
// traffic. Every output is compared against a reference model. The model
// treats the pending word as a one-deep queue and tracks how many busy
// cycles the current word has waited.

module tb_fpu_control_word_apply;

  localparam int TO = 8;

  logic        clk = 1'b0;
  logic        reset;
  logic [15:0] control_word_in;
  logic        control_write;
  logic        fpu_busy;
  logic [5:0]  status_exceptions;
  logic [15:0] active_cw;
  logic [5:0]  exception_mask;
  logic [1:0]  precision_ctl;
  logic [1:0]  rounding_ctl;
  logic        infinity_ctl;
  logic        cw_pending;
  logic        cw_applied;
  logic        cw_overwritten;
  logic        apply_timeout;
  logic        ferr_req;

  int passed = 0;
  int total  = 0;

  // Reference model state.
  logic [15:0] m_active = 16'h037F;
  logic [15:0] m_q[$];
  int          m_age = 0;
  logic        m_timeout = 1'b0;
  logic        m_applied = 1'b0;
  logic        m_over = 1'b0;
  logic        m_ferr = 1'b0;

  fpu_control_word_apply #(.BUSY_TIMEOUT(TO)) dut (
    .clk               (clk),
    .reset             (reset),
    .control_word_in   (control_word_in),
    .control_write     (control_write),
    .fpu_busy          (fpu_busy),
    .status_exceptions (status_exceptions),
    .active_cw         (active_cw),
    .exception_mask    (exception_mask),
    .precision_ctl     (precision_ctl),
    .rounding_ctl      (rounding_ctl),
    .infinity_ctl      (infinity_ctl),
    .cw_pending        (cw_pending),
    .cw_applied        (cw_applied),
    .cw_overwritten    (cw_overwritten),
    .apply_timeout     (apply_timeout),
    .ferr_req          (ferr_req)
  );

  always #5 clk = ~clk;

  // Advances the model by one rising edge, using the inputs present at that edge.
  task automatic modelEdge();
    logic ferr_next;
    ferr_next = !m_active[7] && ((status_exceptions & ~m_active[5:0]) != 6'd0);
    m_applied = 1'b0;
    m_over    = 1'b0;
    if (!reset) begin
      m_active  = 16'h037F;
      m_q.delete();
      m_age     = 0;
      m_timeout = 1'b0;
      ferr_next = 1'b0;
    end else if (m_q.size() == 0) begin
      if (control_write) begin
        m_q.push_back(control_word_in);
        m_age = 0;
      end
    end else if (!fpu_busy) begin
      m_active  = m_q.pop_front();
      m_applied = 1'b1;
      m_timeout = 1'b0;
      if (control_write) begin
        m_q.push_back(control_word_in);
        m_age = 0;
      end
    end else if (control_write) begin
      m_q[0] = control_word_in;
      m_over = 1'b1;
      m_age  = 0;
    end else begin
      m_age++;
      if (m_age == TO) m_timeout = 1'b1;
    end
    m_ferr = ferr_next;
  endtask

  task automatic applyStimulus(input logic rst_n, input logic wr, input logic [15:0] din,
                               input logic busy, input logic [5:0] stat);
    reset             = rst_n;
    control_write     = wr;
    control_word_in   = din;
    fpu_busy          = busy;
    status_exceptions = stat;
    @(posedge clk);
    modelEdge();
    #1;
  endtask

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  task automatic checkOutput();
    logic [15:0] a;
    a = m_active;
    check("active_cw",      active_cw, a);
    check("exception_mask", 16'(exception_mask), 16'(a[5:0]));
    check("precision_ctl",  16'(precision_ctl), 16'(a[9:8]));
    check("rounding_ctl",   16'(rounding_ctl), 16'(a[11:10]));
    check("infinity_ctl",   16'(infinity_ctl), 16'(a[12]));
    check("cw_pending",     16'(cw_pending), 16'(m_q.size() != 0));
    check("cw_applied",     16'(cw_applied), 16'(m_applied));
    check("cw_overwritten", 16'(cw_overwritten), 16'(m_over));
    check("apply_timeout",  16'(apply_timeout), 16'(m_timeout));
    check("ferr_req",       16'(ferr_req), 16'(m_ferr));
  endtask

  initial begin
    $display("[TB] start");

    // Hold reset, then release it and check the reset values.
    applyStimulus(1'b0, 1'b0, 16'h0000, 1'b0, 6'h00);
    applyStimulus(1'b0, 1'b0, 16'h0000, 1'b0, 6'h00);
    checkOutput();
    check("rst_active", active_cw, 16'h037F);
    check("rst_rounding", 16'(rounding_ctl), 16'h0000);
    check("rst_precision", 16'(precision_ctl), 16'h0003);
    check("rst_mask", 16'(exception_mask), 16'h003F);
    check("rst_pending", 16'(cw_pending), 16'h0000);
    check("rst_ferr", 16'(ferr_req), 16'h0000);
    applyStimulus(1'b1, 1'b0, 16'h0000, 1'b0, 6'h00);
    checkOutput();

    // Minimum-latency write with the core idle.
    applyStimulus(1'b1, 1'b1, 16'h0C7F, 1'b0, 6'h00);
    checkOutput();
    check("e0_pending", 16'(cw_pending), 16'h0001);
    check("e0_active", active_cw, 16'h037F);
    applyStimulus(1'b1, 1'b0, 16'h0000, 1'b0, 6'h00);
    checkOutput();
    check("e1_active", active_cw, 16'h0C7F);
    check("e1_rounding", 16'(rounding_ctl), 16'h0003);
    check("e1_applied", 16'(cw_applied), 16'h0001);
    applyStimulus(1'b1, 1'b0, 16'h0000, 1'b0, 6'h00);
    checkOutput();
    check("e2_applied", 16'(cw_applied), 16'h0000);

    // Overwrite while the core is busy.
    applyStimulus(1'b0, 1'b0, 16'h0000, 1'b0, 6'h00);
    applyStimulus(1'b1, 1'b0, 16'h0000, 1'b1, 6'h00);
    checkOutput();
    applyStimulus(1'b1, 1'b1, 16'h027F, 1'b1, 6'h00);
    checkOutput();
    check("ow_first", 16'(cw_overwritten), 16'h0000);
    applyStimulus(1'b1, 1'b1, 16'h007F, 1'b1, 6'h00);
    checkOutput();
    check("ow_second", 16'(cw_overwritten), 16'h0001);
    check("ow_active_held", active_cw, 16'h037F);
    applyStimulus(1'b1, 1'b0, 16'h0000, 1'b1, 6'h00);
    checkOutput();
    check("ow_pulse_end", 16'(cw_overwritten), 16'h0000);
    applyStimulus(1'b1, 1'b0, 16'h0000, 1'b0, 6'h00);
    checkOutput();
    check("ow_commit", active_cw, 16'h007F);

    // Timeout while the core stays busy.
    applyStimulus(1'b1, 1'b1, 16'h0F7F, 1'b1, 6'h00);
    checkOutput();
    for (int i = 1; i <= TO + 5; i++) begin
      applyStimulus(1'b1, 1'b0, 16'h0000, 1'b1, 6'h00);
      checkOutput();
      check("to_flag", 16'(apply_timeout), (i >= TO) ? 16'h0001 : 16'h0000);
    end
    check("to_no_commit", active_cw, 16'h007F);
    check("to_pending", 16'(cw_pending), 16'h0001);
    applyStimulus(1'b1, 1'b0, 16'h0000, 1'b0, 6'h00);
    checkOutput();
    check("to_commit", active_cw, 16'h0F7F);
    check("to_cleared", 16'(apply_timeout), 16'h0000);

    // An unmasked ZE flag raises ferr_req one edge after the commit.
    applyStimulus(1'b0, 1'b0, 16'h0000, 1'b0, 6'h04);
    applyStimulus(1'b1, 1'b1, 16'h037B, 1'b0, 6'h04);
    checkOutput();
    applyStimulus(1'b1, 1'b0, 16'h0000, 1'b0, 6'h04);
    checkOutput();
    check("ferr_at_commit", 16'(ferr_req), 16'h0000);
    applyStimulus(1'b1, 1'b0, 16'h0000, 1'b0, 6'h04);
    checkOutput();
    check("ferr_after", 16'(ferr_req), 16'h0001);

    // With bit 7 set, ferr_req stays low.
    applyStimulus(1'b0, 1'b0, 16'h0000, 1'b0, 6'h04);
    applyStimulus(1'b1, 1'b1, 16'h03FB, 1'b0, 6'h04);
    applyStimulus(1'b1, 1'b0, 16'h0000, 1'b0, 6'h04);
    applyStimulus(1'b1, 1'b0, 16'h0000, 1'b0, 6'h04);
    checkOutput();
    check("ferr_bit7", 16'(ferr_req), 16'h0000);

    // Reset while a write is pending and the core is busy.
    applyStimulus(1'b1, 1'b1, 16'h0A5A, 1'b1, 6'h00);
    applyStimulus(1'b1, 1'b0, 16'h0000, 1'b1, 6'h00);
    checkOutput();
    applyStimulus(1'b0, 1'b0, 16'h0000, 1'b1, 6'h00);
    checkOutput();
    check("rp_pending", 16'(cw_pending), 16'h0000);
    check("rp_active", active_cw, 16'h037F);
    applyStimulus(1'b1, 1'b0, 16'h0000, 1'b0, 6'h00);
    checkOutput();
    applyStimulus(1'b1, 1'b0, 16'h0000, 1'b0, 6'h00);
    checkOutput();
    check("rp_no_commit", 16'(cw_applied), 16'h0000);
    check("rp_active_kept", active_cw, 16'h037F);

    // Random traffic, weighted toward a busy core so timeouts occur.
    for (int i = 0; i < 600; i++) begin
      applyStimulus(($urandom_range(0, 63) != 0), ($urandom_range(0, 3) == 0),
                    16'($urandom), ($urandom_range(0, 7) < 6), 6'($urandom));
      checkOutput();
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
